// File: rtl/latch_write_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// latch_write_arbiter_if : requester/latch-bank bus for latch_write_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface latch_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      latch_d;
  logic                  latch_en;
  logic                  busy;
  logic [GID_W-1:0]      grant_id;
  logic [WIDTH-1:0]      last_data;

  modport master (
    output req, wdata,
    input  ack, latch_d, latch_en, busy, grant_id, last_data
  );

  modport slave (
    input  req, wdata,
    output ack, latch_d, latch_en, busy, grant_id, last_data
  );
endinterface
`default_nettype wire

// File: rtl/latch_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// latch_write_arbiter : round-robin writer for a shared bank of D latches
// Revision: 1.0
// ---------------------------------------------------------------------------
module latch_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  latch_write_arbiter_if.slave  bus
);
  localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EN_CYCLES - 1);
  localparam logic [GID_W-1:0] GID_LAST = GID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  latch_d_q, latch_d_d;
  logic              latch_en_q, latch_en_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;
  logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  last_data_q, last_data_d;

  logic              pick_valid;
  logic [GID_W-1:0]  pick_id;

  // First requesting index at or after rr_ptr, searching with wrap-around.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_valid && bus.req[(int'(rr_ptr_q) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_id    = GID_W'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_d_d   = latch_d_q;
    latch_en_d  = 1'b0;
    ack_d       = '0;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    last_data_d = last_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_SETUP;
          grant_id_d = pick_id;
          latch_d_d  = bus.wdata[pick_id*WIDTH +: WIDTH];
        end
      end
      ST_SETUP: begin
        state_d    = ST_ENABLE;
        cnt_d      = CNT_LOAD;
        latch_en_d = 1'b1;
      end
      ST_ENABLE: begin
        if (cnt_q == '0) begin
          state_d           = ST_HOLD;
          ack_d[grant_id_q] = 1'b1;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          latch_en_d = 1'b1;
        end
      end
      ST_HOLD: begin
        state_d     = ST_IDLE;
        last_data_d = latch_d_q;
        rr_ptr_d    = (grant_id_q == GID_LAST) ? '0 : grant_id_q + GID_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // En, D and ack are all registered so the latch pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      latch_d_q   <= '0;
      latch_en_q  <= 1'b0;
      ack_q       <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      latch_d_q   <= latch_d_d;
      latch_en_q  <= latch_en_d;
      ack_q       <= ack_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      last_data_q <= last_data_d;
    end
  end

  assign bus.latch_d   = latch_d_q;
  assign bus.latch_en  = latch_en_q;
  assign bus.ack       = ack_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.last_data = last_data_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_latch_write_arbiter : self-checking bench for latch_write_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_latch_write_arbiter;
  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int EN_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  latch_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  latch_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .EN_CYCLES(EN_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural latch bank driven by the DUT pins.
  logic [WIDTH-1:0] lat_q;
  always_latch if (bus.latch_en) lat_q <= bus.latch_d;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    int          gid;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[6];

  // Transaction-level reference model state.
  bit         m_act;
  int         m_t0, m_gid, m_rr;
  logic [7:0] m_data, m_last, m_latch_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst     = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic run_write(input vec_t v);
    bus.req   = v.req;
    bus.wdata = v.wdata;
    tick();
    chk("vec_setup_busy", bus.busy, 1);
    chk("vec_setup_gid", bus.grant_id, v.gid);
    chk("vec_setup_d", bus.latch_d, v.data);
    chk("vec_setup_en", bus.latch_en, 0);
    for (int c = 2; c <= EN_CYCLES + 1; c++) begin
      tick();
      chk("vec_en_high", bus.latch_en, 1);
      chk("vec_en_d", bus.latch_d, v.data);
      chk("vec_en_ack", bus.ack, 0);
    end
    tick();
    chk("vec_hold_ack", bus.ack, 32'(1) << v.gid);
    chk("vec_hold_en", bus.latch_en, 0);
    bus.req = '0;
    tick();
    chk("vec_idle_busy", bus.busy, 0);
    chk("vec_idle_ack", bus.ack, 0);
    chk("vec_last_data", bus.last_data, v.data);
    chk("vec_latch_q", lat_q, v.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] r;
    logic [7:0] saved;
    bit         got_ack;
    int         off;

    vecs[0] = '{4'b0100, 32'h11A52233, 2, 8'hA5};
    vecs[1] = '{4'b0011, 32'h44332211, 0, 8'h11};
    vecs[2] = '{4'b1001, 32'hDE0000BE, 3, 8'hDE};
    vecs[3] = '{4'b1111, 32'h88776655, 0, 8'h55};
    vecs[4] = '{4'b0001, 32'h000000C3, 0, 8'hC3};
    vecs[5] = '{4'b1110, 32'h0F0E0D0C, 1, 8'h0D};

    // Reset with random traffic on the inputs.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req   = 4'($urandom_range(1, 15));
      bus.wdata = $urandom();
      tick();
    end
    chk("rst_latch_en", bus.latch_en, 0);
    chk("rst_latch_d", bus.latch_d, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_last_data", bus.last_data, 0);
    bus.req = '0;
    rst     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_en", bus.latch_en, 0);
    end

    // Table of single writes, pointer carried across entries.
    foreach (vecs[i]) run_write(vecs[i]);

    // Round-robin under continuous request from a fresh pointer.
    do_reset();
    bus.req   = 4'b1111;
    bus.wdata = 32'h44332211;
    for (int c = 1; c <= 25; c++) begin
      tick();
      chk("rr_ack", bus.ack, (c % 5 == 4) ? (32'(1) << ((c / 5) % 4)) : 32'(0));
      chk("rr_busy", bus.busy, (c % 5 != 0) ? 32'(1) : 32'(0));
      if (c % 5 == 4) begin
        chk("rr_latch_d", bus.latch_d, 32'(((c / 5) % 4 + 1) * 8'h11));
        if (c == 24) bus.req = '0;
      end
    end

    // Data and req changes after grant do not disturb the write.
    bus.req   = 4'b0010;
    bus.wdata = 32'h00003C00;
    tick();
    chk("late_gid", bus.grant_id, 1);
    chk("late_setup_d", bus.latch_d, 8'h3C);
    bus.wdata = 32'h0000FF00;
    bus.req   = '0;
    tick();
    tick();
    chk("late_en_d", bus.latch_d, 8'h3C);
    tick();
    chk("late_ack", bus.ack, 4'b0010);
    chk("late_hold_d", bus.latch_d, 8'h3C);
    tick();
    chk("late_last_data", bus.last_data, 8'h3C);
    chk("late_busy", bus.busy, 0);

    // Asynchronous reset during the first En-high cycle.
    bus.req   = 4'b1000;
    bus.wdata = 32'h5A000000;
    tick();
    tick();
    chk("mid_en_before", bus.latch_en, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", bus.latch_en, 0);
    chk("mid_rst_d", bus.latch_d, 0);
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_busy", bus.busy, 0);
    tick();
    chk("mid_rst_ack2", bus.ack, 0);
    rst     = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 12 && !got_ack; i++) begin
      tick();
      if (bus.ack != '0) got_ack = 1'b1;
    end
    chk("mid_rearb_ack", bus.ack, 4'b1000);
    bus.req = '0;
    tick();
    chk("mid_last_data", bus.last_data, 8'h5A);
    chk("mid_latch_q", lat_q, 8'h5A);

    // Latch contents hold while idle with wdata toggling.
    saved = lat_q;
    for (int i = 0; i < 20; i++) begin
      bus.wdata = $urandom();
      tick();
      chk("hold_q", lat_q, saved);
      chk("hold_en", bus.latch_en, 0);
    end

    // Random traffic against the timeline model.
    do_reset();
    m_act = 1'b0; m_t0 = 0; m_gid = 0; m_rr = 0;
    m_data = '0; m_last = '0; m_latch_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (m_act && (c - m_t0) >= EN_CYCLES + 3) begin
        m_act  = 1'b0;
        m_last = m_data;
        m_rr   = (m_gid + 1) % NREQ;
        chk("rnd_commit_q", lat_q, m_last);
      end
      off = c - m_t0;
      chk("rnd_busy", bus.busy, m_act);
      chk("rnd_en", bus.latch_en, (m_act && off >= 2 && off <= EN_CYCLES + 1) ? 32'(1) : 32'(0));
      chk("rnd_ack", bus.ack, (m_act && off == EN_CYCLES + 2) ? (32'(1) << m_gid) : 32'(0));
      chk("rnd_latch_d", bus.latch_d, m_latch_d);
      chk("rnd_gid", bus.grant_id, m_gid);
      chk("rnd_last_data", bus.last_data, m_last);
      r         = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.req   = r;
      bus.wdata = $urandom();
      if (!m_act && r != 0) begin
        m_gid     = rr_pick(r, m_rr);
        m_data    = bus.wdata[m_gid*8 +: 8];
        m_latch_d = m_data;
        m_t0      = c;
        m_act     = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
